// File: rtl/dmem_ctrl.sv
// Data-memory controller: registers a MEM-stage load/store into a dcache request and stalls the pipe until the response.
// Optional performance counters are built only when DMEM_PERF_CNT_EN is defined.
//
//   state | meaning
//   IDLE  | no transaction; a MEM request is latched into dc_* at the next edge
//   BUSY  | dcache request outstanding; dc_* held stable until dc_resp
//   DONE  | response captured; one cycle where MEM inputs are ignored
module dmem_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic [31:0]       mem_wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [3:0]        mem_byte_en,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic [31:0]       dc_address,
  output logic [31:0]       dc_wdata,
  output logic [3:0]        dc_byte_en,
  output logic              dc_read,
  output logic              dc_write,
  input  logic [31:0]       dc_rdata,
  input  logic              dc_resp,
  output logic [PERF_W-1:0] perf_loads,
  output logic [PERF_W-1:0] perf_stores,
  output logic [PERF_W-1:0] perf_stall_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   req;
  logic   start;
  logic   finish;

  assign req = mem_read | mem_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (dc_resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall is forced low while in reset so a held request cannot freeze the pipe.
  always_comb begin
    start     = 1'b0;
    finish    = 1'b0;
    mem_stall = 1'b0;
    case (state)
      IDLE: begin
        start     = req;
        mem_stall = rst & req;
      end
      BUSY: begin
        finish    = dc_resp;
        mem_stall = rst;
      end
      default: ;
    endcase
  end

  // A simultaneous read+write is issued as a write so the strobes stay exclusive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dc_address <= '0;
      dc_wdata   <= '0;
      dc_byte_en <= '0;
      dc_read    <= 1'b0;
      dc_write   <= 1'b0;
      mem_rdata  <= '0;
    end else if (start) begin
      dc_address <= mem_address;
      dc_wdata   <= mem_wdata;
      dc_byte_en <= mem_byte_en;
      dc_read    <= mem_read & ~mem_write;
      dc_write   <= mem_write;
    end else if (finish) begin
      dc_read    <= 1'b0;
      dc_write   <= 1'b0;
      if (dc_read) mem_rdata <= dc_rdata;
    end
  end

`ifdef DMEM_PERF_CNT_EN
  localparam logic [PERF_W-1:0] ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic load_start;
  logic store_start;

  assign load_start  = start & mem_read & ~mem_write;
  assign store_start = start & mem_write;

  // Counters saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_loads        <= '0;
      perf_stores       <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (load_start && perf_loads != '1)        perf_loads        <= perf_loads + ONE;
      if (store_start && perf_stores != '1)      perf_stores       <= perf_stores + ONE;
      if (mem_stall && perf_stall_cycles != '1)  perf_stall_cycles <= perf_stall_cycles + ONE;
    end
  end
`else
  assign perf_loads        = '0;
  assign perf_stores       = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed loads/stores, reset abort, stray responses and counter saturation.
module tb_dmem_ctrl;

`ifdef DMEM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_en;
  logic [31:0] dc_rdata;
  logic        dc_resp;

  logic [31:0] mem_rdata, dc_address, dc_wdata;
  logic        mem_stall, dc_read, dc_write;
  logic [3:0]  dc_byte_en;
  logic [31:0] perf_loads, perf_stores, perf_stall_cycles;

  logic [31:0] s_mem_rdata, s_dc_address, s_dc_wdata;
  logic        s_mem_stall, s_dc_read, s_dc_write;
  logic [3:0]  s_dc_byte_en;
  logic [1:0]  s_perf_loads, s_perf_stores, s_perf_stall_cycles;

  dmem_ctrl #(.PERF_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .dc_address(dc_address), .dc_wdata(dc_wdata), .dc_byte_en(dc_byte_en),
    .dc_read(dc_read), .dc_write(dc_write),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_stall_cycles(perf_stall_cycles)
  );

  // Narrow-counter copy sharing all stimulus, used to reach saturation quickly.
  dmem_ctrl #(.PERF_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
    .mem_rdata(s_mem_rdata), .mem_stall(s_mem_stall),
    .dc_address(s_dc_address), .dc_wdata(s_dc_wdata), .dc_byte_en(s_dc_byte_en),
    .dc_read(s_dc_read), .dc_write(s_dc_write),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .perf_loads(s_perf_loads), .perf_stores(s_perf_stores),
    .perf_stall_cycles(s_perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_run = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pe(input int v);
    return PERF ? 32'(v) : 32'h0;
  endfunction

  // Monitor: a falling mem_stall outside reset marks a completed transaction.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      stall_run = 0;
    end else if (mem_stall) begin
      stall_run++;
    end else if (stall_run != 0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_completion", 32'(stall_run), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check("mem_rdata", mem_rdata, e.rdata);
        check("sat_mem_rdata", s_mem_rdata, e.rdata);
        check("stall_cycles", 32'(stall_run), 32'(e.stalls));
      end
      stall_run = 0;
    end
  end

  // d = number of BUSY cycles; dc_resp is pulsed in the last one.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr,
                        input logic [3:0] be, input int d, input logic [31:0] rdat);
    exp_t e;
    @(posedge clk); #1;
    mem_address = a; mem_wdata = wd; mem_read = rd; mem_write = wr; mem_byte_en = be;
    if (rd && !wr) last_rdata = rdat;
    e.rdata = last_rdata;
    e.stalls = d + 1;
    sb_q.push_back(e);
    for (int i = 1; i <= d; i++) begin
      @(posedge clk); #1;
      check("dc_address", dc_address, a);
      check("dc_wdata", dc_wdata, wd);
      check("dc_byte_en", {28'h0, dc_byte_en}, {28'h0, be});
      check("dc_read", {31'h0, dc_read}, {31'h0, rd & ~wr});
      check("dc_write", {31'h0, dc_write}, {31'h0, wr});
      check("sat_dc_address", s_dc_address, a);
      check("sat_dc_wdata", s_dc_wdata, wd);
      check("sat_dc_byte_en", {28'h0, s_dc_byte_en}, {28'h0, be});
      check("sat_strobes", {30'h0, s_dc_read, s_dc_write}, {30'h0, rd & ~wr, wr});
      check("sat_mem_stall", {31'h0, s_mem_stall}, 32'h1);
      if (i == d) begin
        dc_resp = 1'b1; dc_rdata = rdat;
      end else begin
        dc_rdata = ~rdat;
      end
    end
    @(posedge clk); #1;
    dc_resp = 1'b0; dc_rdata = 32'h0BAD_F00D;
    check("done_strobes", {30'h0, dc_read, dc_write}, 32'h0);
    check("done_stall", {31'h0, mem_stall}, 32'h0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; dc_resp = 1'b0;
    @(negedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    last_rdata = 32'h0;
  endtask

  task automatic check_perf(input string tag, input int ld, input int st, input int sc,
                            input int s_ld, input int s_st, input int s_sc);
    check({tag, "_perf_loads"}, perf_loads, pe(ld));
    check({tag, "_perf_stores"}, perf_stores, pe(st));
    check({tag, "_perf_stall"}, perf_stall_cycles, pe(sc));
    check({tag, "_sat_loads"}, {30'h0, s_perf_loads}, pe(s_ld));
    check({tag, "_sat_stores"}, {30'h0, s_perf_stores}, pe(s_st));
    check({tag, "_sat_stall"}, {30'h0, s_perf_stall_cycles}, pe(s_sc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mem_address = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_en = '0;
    dc_rdata = '0; dc_resp = 1'b0;
    #1 rst = 1'b0;
    mem_read = 1'b1; mem_write = 1'b1; mem_address = 32'hFFFF_FFF0;
    #2;
    check("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
    check("rst_strobes", {30'h0, dc_read, dc_write}, 32'h0);
    check("rst_dc_address", dc_address, 32'h0);
    check("rst_dc_wdata", dc_wdata, 32'h0);
    check("rst_dc_byte_en", {28'h0, dc_byte_en}, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check_perf("rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    #2 rst = 1'b1;

    // Single load, response one cycle after the strobe
    do_req(32'h0000_1000, 32'h0, 1'b1, 1'b0, 4'b1111, 1, 32'hDEAD_BEEF);
    check("load_rdata_done", mem_rdata, 32'hDEAD_BEEF);
    // Store with a five-cycle response; read data must not move
    do_req(32'h0000_2004, 32'h0000_AB00, 1'b0, 1'b1, 4'b0010, 5, 32'h1234_5678);
    idle();

    // Stray response while idle is ignored
    @(posedge clk); #1;
    dc_resp = 1'b1; dc_rdata = 32'h5555_AAAA;
    check("stray_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    dc_resp = 1'b0;
    check("stray_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("stray_strobes", {30'h0, dc_read, dc_write}, 32'h0);

    // Reset in the second BUSY cycle, then a late response
    @(posedge clk); #1;
    mem_address = 32'h0000_3000; mem_read = 1'b1; mem_write = 1'b0; mem_byte_en = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    check("abort_strobes", {30'h0, dc_read, dc_write}, 32'h0);
    check("abort_dc_address", dc_address, 32'h0);
    check("abort_dc_wdata", dc_wdata, 32'h0);
    check("abort_dc_byte_en", {28'h0, dc_byte_en}, 32'h0);
    check("abort_mem_rdata", mem_rdata, 32'h0);
    check("abort_mem_stall", {31'h0, mem_stall}, 32'h0);
    last_rdata = 32'h0;
    @(negedge clk);
    mem_read = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    dc_resp = 1'b1; dc_rdata = 32'hCAFE_F00D;
    check("abort_resp_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    dc_resp = 1'b0;
    check("abort_resp_rdata", mem_rdata, 32'h0);
    check("abort_resp_strobes", {30'h0, dc_read, dc_write}, 32'h0);
    check_perf("abort", 0, 0, 0, 0, 0, 0);

    // Simultaneous read and write is a write
    do_req(32'h0000_4008, 32'h0102_0304, 1'b1, 1'b1, 4'b1100, 2, 32'h7777_7777);
    idle();
    check("rw_rdata", mem_rdata, 32'h0);
    check_perf("rw", 0, 1, 3, 0, 1, 3);

    // Back-to-back loads, then one more to push the narrow counters past all-ones
    do_reset();
    do_req(32'h0000_5000, 32'h0, 1'b1, 1'b0, 4'hF, 1, 32'h1111_0001);
    do_req(32'h0000_5004, 32'h0, 1'b1, 1'b0, 4'hF, 1, 32'h2222_0002);
    do_req(32'h0000_5008, 32'h0, 1'b1, 1'b0, 4'hF, 1, 32'h3333_0003);
    idle();
    check_perf("b2b", 3, 0, 6, 3, 0, 3);
    do_req(32'h0000_500C, 32'h0, 1'b1, 1'b0, 4'hF, 1, 32'h4444_0004);
    idle();
    check_perf("sat", 4, 0, 8, 3, 0, 3);
    check("final_rdata", mem_rdata, 32'h4444_0004);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: PERF_W, 32, width of each performance counter.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: mem_address  in  32  word-aligned address from MEM stage.
REQ-006 Port: mem_wdata  in  32  lane-shifted store data from MEM stage.
REQ-007 Port: mem_read  in  1  load request from MEM stage.
REQ-008 Port: mem_write  in  1  store request from MEM stage.
REQ-009 Port: mem_byte_en  in  4  byte enables from MEM stage.
REQ-010 Port: mem_rdata  out  32  captured load data to MEM stage.
REQ-011 Port: mem_stall  out  1  freeze request to the pipeline.
REQ-012 Port: dc_address, dc_wdata, dc_byte_en  out  32/32/4  registered request to dcache.
REQ-013 Port: dc_read, dc_write  out  1/1  registered dcache strobes.
REQ-014 Port: dc_rdata  in  32  dcache read data.
REQ-015 Port: dc_resp  in  1  dcache completion, one-cycle pulse.
REQ-016 Port: perf_loads, perf_stores, perf_stall_cycles  out  PERF_W each  counters (macro-gated).

Function
REQ-017 FSM states: IDLE, BUSY, DONE.
REQ-018 IDLE with mem_read or mem_write high: at the clock edge, capture address, wdata, and byte_en into dc_* and set the strobe; go to BUSY.
REQ-019 Simultaneous mem_read and mem_write: treat as a write; dc_read stays 0.
REQ-020 BUSY: hold all dc_* stable until dc_resp=1; on dc_resp, clear strobes, capture dc_rdata into mem_rdata (loads only), and go to DONE.
REQ-021 DONE: unconditionally return to IDLE next edge; MEM inputs are ignored in DONE, so the finishing instruction is never re-issued.
REQ-022 mem_stall (combinational): 1 in BUSY; 1 in IDLE when mem_read|mem_write; 0 in DONE; 0 in IDLE with no request.
REQ-023 Latency: request visible in cycle N with dc_resp in cycle N+1 gives DONE in N+2; the minimum is 2 stall cycles.
REQ-024 mem_rdata holds its last captured value and is unchanged by stores.
REQ-025 dc_resp outside BUSY is ignored.
REQ-026 dc_read and dc_write are never high together.

Reset
REQ-027 On rst=0, immediately (asynchronously): state=IDLE; dc_read=dc_write=0; dc_address=dc_wdata=0; dc_byte_en=0; mem_rdata=0; counters=0.
REQ-028 Reset mid-BUSY abandons the transaction; a following dc_resp is ignored per REQ-025.
REQ-029 mem_stall is 0 during reset regardless of inputs.

Configuration
REQ-030 Macro DMEM_PERF_CNT_EN defined: the counters are implemented.
- perf_loads increments on each load entering BUSY.
- perf_stores increments on each store entering BUSY.
- perf_stall_cycles increments every cycle mem_stall=1.
- All counters saturate at all-ones.
REQ-031 Macro undefined: the perf_* ports remain and are tied to 0; no counter flops are instantiated.

Verification
REQ-032 Load 0x0000_1000 with dc_resp one cycle after the strobe and dc_rdata=0xDEAD_BEEF -> mem_stall high for 2 cycles; mem_rdata=0xDEAD_BEEF in DONE.
REQ-033 Store 0x0000_2004, wdata 0x0000_AB00, byte_en 0010, dc_resp delayed 5 cycles -> dc_* stable for all 5 cycles; mem_stall high for 6 cycles; mem_rdata unchanged.
REQ-034 mem_read=mem_write=1 -> dc_write=1 and dc_read=0; with the macro defined, perf_stores=1 and perf_loads=0.
REQ-035 rst asserted in the 2nd BUSY cycle, then dc_resp pulses after release -> outputs reach reset values without a clock; state stays IDLE; mem_rdata=0.
REQ-036 With the macro defined, 3 back-to-back loads with 1-cycle resp -> perf_loads=3, perf_stall_cycles=6; with the counter preloaded to all-ones, the counter stays all-ones.
